// File: rtl/e_muldiv.sv
// E-stage multiply/divide unit: owns HI/LO, runs mult/div ops over a fixed
// number of busy cycles, and serves mfhi/mflo/mthi/mtlo.
module e_muldiv #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  E_MDOp,
  input  logic [31:0] E_rs_data,
  input  logic [31:0] E_rt_data,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] E_MDOut
);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8
  } md_op_e;

  typedef enum logic {IDLE, RUN} state_e;

  state_e      state, state_nxt;
  logic [3:0]  counter;
  logic [31:0] shadow_hi, shadow_lo;
  logic        shadow_wr;

  logic        launch;
  logic [31:0] res_hi, res_lo;
  logic        res_wr;

  // Arithmetic: sign extension to 64 bits makes one unsigned multiplier
  // produce the exact signed product modulo 2^64.
  logic [63:0] mult_s, mult_u;
  logic [31:0] b_safe, abs_a, abs_b, mag_q, mag_r, div_q, div_r, divu_q, divu_r;

  assign mult_u = {32'd0, E_rs_data} * {32'd0, E_rt_data};
  assign mult_s = {{32{E_rs_data[31]}}, E_rs_data} * {{32{E_rt_data[31]}}, E_rt_data};

  // A zero divisor never commits, but keep the dividers away from x/0.
  assign b_safe = (E_rt_data == 32'd0) ? 32'd1 : E_rt_data;
  assign divu_q = E_rs_data / b_safe;
  assign divu_r = E_rs_data % b_safe;
  assign abs_a  = E_rs_data[31] ? -E_rs_data : E_rs_data;
  assign abs_b  = b_safe[31] ? -b_safe : b_safe;
  assign mag_q  = abs_a / abs_b;
  assign mag_r  = abs_a % abs_b;
  assign div_q  = (E_rs_data[31] ^ b_safe[31]) ? -mag_q : mag_q;
  assign div_r  = E_rs_data[31] ? -mag_r : mag_r;

  assign launch = (state == IDLE) && start &&
                  (E_MDOp inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU});

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    res_wr = 1'b0;
    case (E_MDOp)
      OP_MULT:  begin res_hi = mult_s[63:32]; res_lo = mult_s[31:0]; res_wr = 1'b1; end
      OP_MULTU: begin res_hi = mult_u[63:32]; res_lo = mult_u[31:0]; res_wr = 1'b1; end
      OP_DIV:   begin res_hi = div_r;  res_lo = div_q;  res_wr = (E_rt_data != 32'd0); end
      OP_DIVU:  begin res_hi = divu_r; res_lo = divu_q; res_wr = (E_rt_data != 32'd0); end
      default:  ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (launch) state_nxt = RUN;
      RUN:     if (counter == 4'd1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      counter   <= 4'd0;
      shadow_hi <= 32'd0;
      shadow_lo <= 32'd0;
      shadow_wr <= 1'b0;
      HI        <= 32'd0;
      LO        <= 32'd0;
    end else if (state == RUN) begin
      // HI/LO hold their old value until the final busy edge.
      counter <= counter - 4'd1;
      if (counter == 4'd1 && shadow_wr) begin
        HI <= shadow_hi;
        LO <= shadow_lo;
      end
    end else if (launch) begin
      counter   <= (E_MDOp inside {OP_MULT, OP_MULTU}) ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
      shadow_hi <= res_hi;
      shadow_lo <= res_lo;
      shadow_wr <= res_wr;
    end else if (E_MDOp == OP_MTHI) begin
      HI <= E_rs_data;
    end else if (E_MDOp == OP_MTLO) begin
      LO <= E_rs_data;
    end
  end

  assign busy = (state == RUN);

  // Reads see only committed HI/LO; an in-flight result is never bypassed.
  always_comb begin
    E_MDOut = 32'd0;
    if (E_MDOp == OP_MFHI)      E_MDOut = HI;
    else if (E_MDOp == OP_MFLO) E_MDOut = LO;
  end

endmodule

// File: tb/tb_e_muldiv.sv
// Directed self-checking bench for e_muldiv (MULT_CYCLES=5, DIV_CYCLES=10).
module tb_e_muldiv;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  E_MDOp;
  logic [31:0] E_rs_data, E_rt_data;
  logic        busy;
  logic [31:0] HI, LO, E_MDOut;

  int n_cmp = 0;
  int n_bad = 0;

  e_muldiv #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .E_MDOp(E_MDOp),
    .E_rs_data(E_rs_data), .E_rt_data(E_rt_data),
    .busy(busy), .HI(HI), .LO(LO), .E_MDOut(E_MDOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge (edge T), then check busy over T..T+n-1 with
  // HI/LO unchanged, and the committed result after edge T+n.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n,
                        input logic [31:0] old_hi, input logic [31:0] old_lo,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    start = 1'b1; E_MDOp = op; E_rs_data = a; E_rt_data = b;
    tick();
    start = 1'b0; E_MDOp = 4'd0;
    for (int i = 0; i < n; i++) begin
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      check({tag, "_hold_hi"}, HI, old_hi);
      check({tag, "_hold_lo"}, LO, old_lo);
      tick();
    end
    check({tag, "_done_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_hi"}, HI, exp_hi);
    check({tag, "_lo"}, LO, exp_lo);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; E_MDOp = 4'd0; E_rs_data = 32'd0; E_rt_data = 32'd0;
    repeat (3) tick();
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    tick();

    run_op("mult",  4'd1, 32'hFFFFFFFE, 32'h3, MC, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("multu", 4'd2, 32'hFFFFFFFE, 32'h3, MC, 32'hFFFFFFFF, 32'hFFFFFFFA, 32'h2, 32'hFFFFFFFA);
    run_op("div",   4'd3, 32'hFFFFFFF9, 32'h2, DC, 32'h2, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu",  4'd4, 32'h7, 32'h2, DC, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'h1, 32'h3);

    // mthi/mtlo set up known HI/LO, then a divide by zero must leave them.
    E_MDOp = 4'd7; E_rs_data = 32'h11; tick();
    check("mthi_11", HI, 32'h11);
    E_MDOp = 4'd8; E_rs_data = 32'h22; tick();
    check("mtlo_22", LO, 32'h22);
    check("mtlo_keep_hi", HI, 32'h11);
    E_MDOp = 4'd0;
    run_op("div0",  4'd3, 32'h5, 32'h0, DC, 32'h11, 32'h22, 32'h11, 32'h22);
    run_op("divu0", 4'd4, 32'h5, 32'h0, DC, 32'h11, 32'h22, 32'h11, 32'h22);
    run_op("divmin", 4'd3, 32'h80000000, 32'hFFFFFFFF, DC, 32'h11, 32'h22, 32'h0, 32'h80000000);
    run_op("divneg", 4'd3, 32'h7, 32'hFFFFFFFE, DC, 32'h0, 32'h80000000, 32'h1, 32'hFFFFFFFD);

    // Idle mthi and mfhi/mflo reads.
    E_MDOp = 4'd7; E_rs_data = 32'hDEADBEEF; tick();
    check("mthi_dead", HI, 32'hDEADBEEF);
    E_MDOp = 4'd5; #1;
    check("mfhi", E_MDOut, 32'hDEADBEEF);
    E_MDOp = 4'd6; #1;
    check("mflo", E_MDOut, 32'hFFFFFFFD);
    E_MDOp = 4'd0; #1;
    check("mdout_none", E_MDOut, 32'h0);

    // Start with a non-launching op code must not raise busy.
    start = 1'b1; E_MDOp = 4'd9; E_rs_data = 32'h2; E_rt_data = 32'h3; tick();
    check("op9_busy", {31'd0, busy}, 32'd0);
    E_MDOp = 4'd5; tick();
    check("op5_busy", {31'd0, busy}, 32'd0);
    start = 1'b0; E_MDOp = 4'd0;

    // mthi while busy is ignored; mfhi shows committed HI, not the shadow.
    start = 1'b1; E_MDOp = 4'd1; E_rs_data = 32'h2; E_rt_data = 32'h3; tick();
    start = 1'b0; E_MDOp = 4'd7; E_rs_data = 32'h12345678; tick();
    check("mthi_busy_ignored", HI, 32'hDEADBEEF);
    E_MDOp = 4'd5; #1;
    check("mfhi_no_bypass", E_MDOut, 32'hDEADBEEF);
    E_MDOp = 4'd0;
    for (int i = 2; i < MC; i++) begin
      check("mthi_busy_span", {31'd0, busy}, 32'd1);
      tick();
    end
    check("mult23_hi_hold", HI, 32'hDEADBEEF);
    tick();
    check("mult23_busy", {31'd0, busy}, 32'd0);
    check("mult23_hi", HI, 32'h0);
    check("mult23_lo", LO, 32'h6);

    // Back-to-back: start held high; the completion edge ignores it, the
    // following edge relaunches with the operands present then.
    start = 1'b1; E_MDOp = 4'd1; E_rs_data = 32'hFFFFFFFE; E_rt_data = 32'h3; tick();
    for (int i = 0; i < MC; i++) begin
      check("b2b_busy1", {31'd0, busy}, 32'd1);
      tick();
    end
    check("b2b_gap_busy", {31'd0, busy}, 32'd0);
    check("b2b_first_hi", HI, 32'hFFFFFFFF);
    check("b2b_first_lo", LO, 32'hFFFFFFFA);
    E_MDOp = 4'd2; tick();
    start = 1'b0; E_MDOp = 4'd0;
    for (int i = 0; i < MC; i++) begin
      check("b2b_busy2", {31'd0, busy}, 32'd1);
      check("b2b_hold_hi", HI, 32'hFFFFFFFF);
      tick();
    end
    check("b2b_done_busy", {31'd0, busy}, 32'd0);
    check("b2b_second_hi", HI, 32'h2);
    check("b2b_second_lo", LO, 32'hFFFFFFFA);

    // Reset mid-run: HI/LO clear at once and the aborted op never commits.
    start = 1'b1; E_MDOp = 4'd1; E_rs_data = 32'h2; E_rt_data = 32'h3; tick();
    start = 1'b0; E_MDOp = 4'd0;
    tick();
    reset = 1'b0; #1;
    check("midrst_hi", HI, 32'h0);
    check("midrst_lo", LO, 32'h0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    #2 reset = 1'b1;
    tick();
    check("postrst_busy", {31'd0, busy}, 32'd0);
    repeat (MC + 2) tick();
    check("postrst_hi", HI, 32'h0);
    check("postrst_lo", LO, 32'h0);
    check("postrst_busy_late", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
